// File: rtl/join_arb_pkg.sv
// Shared state type, reset constants and width helper for the JOIN-stage grant arbiter.
package join_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_e;

  localparam arb_state_e STATE_RST = ST_IDLE;
  localparam int         PTR_RST   = 0;
  localparam int         GCW       = 4;

  function automatic int idxw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/join_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after the base index,
// wrapping; the base is the pointer in round-robin mode and 0 in fixed-priority mode.
module join_rr_pick
  import join_arb_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int IDXW = idxw(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  input  logic            rr_i,
  output logic            valid_o,
  output logic [IDXW-1:0] idx_o
);

  int base;

  // Scan from the far end down so the closest candidate to the base is assigned last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    base    = rr_i ? int'(ptr_i) : 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req_i[(base + k) % N_CH]) begin
        valid_o = 1'b1;
        idx_o   = IDXW'((base + k) % N_CH);
      end
    end
  end

endmodule

// File: rtl/join_rr_arbiter.sv
// N-channel JOIN-stage grant arbiter: registered one-hot 4-phase grant, guard gap after
// each release, optional hold watchdog. state | meaning: IDLE | evaluate requests;
// GRANT | hold grant until owner releases or watchdog fires; GUARD | forced all-low gap.
module join_rr_arbiter
  import join_arb_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int MODE_RR  = 1,
  parameter int GUARD    = 1,
  parameter int HOLD_MAX = 0
) (
  input  logic                     CLK,
  input  logic                     MR,
  input  logic [N_CH-1:0]          Send_in,
  input  logic [N_CH-1:0]          Ack_out,
  input  logic [N_CH-1:0]          Z,
  output logic [N_CH-1:0]          G,
  output logic [idxw(N_CH)-1:0]    grant_idx,
  output logic                     busy,
  output logic                     hold_err
);

  localparam int IDXW = idxw(N_CH);
  localparam int HW   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HW-1:0]  HOLD_LAST  = HW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
  localparam logic [GCW-1:0] GUARD_LAST = GCW'((GUARD > 0) ? GUARD - 1 : 0);

  arb_state_e      state_q, state_d;
  logic [N_CH-1:0] g_q, g_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [GCW-1:0]  guard_q, guard_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            err_q, err_d;

  logic [N_CH-1:0] req;
  logic            req_w;
  logic            wd_fire;
  logic            pick_valid;
  logic [IDXW-1:0] pick_idx;
  logic [IDXW-1:0] ptr_nxt;

  assign req     = Send_in & Ack_out & Z;
  assign req_w   = req[idx_q];
  assign wd_fire = (HOLD_MAX > 0) && (hold_q == HOLD_LAST);
  assign ptr_nxt = (idx_q == IDXW'(N_CH - 1)) ? '0 : idx_q + IDXW'(1);

  join_rr_pick #(
    .N_CH (N_CH),
    .IDXW (IDXW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .rr_i    (MODE_RR != 0),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    guard_d = guard_q;
    hold_d  = hold_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          g_d     = N_CH'(1) << pick_idx;
          idx_d   = pick_idx;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        // A watchdog release only counts as an error if the owner was still requesting.
        if (!req_w || wd_fire) begin
          g_d = '0;
          if (req_w) err_d = 1'b1;
          if (MODE_RR != 0) ptr_d = ptr_nxt;
          if (GUARD > 0) begin
            state_d = ST_GUARD;
            guard_d = GUARD_LAST;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_GUARD: begin
        if (guard_q == '0) state_d = ST_IDLE;
        else               guard_d = guard_q - GCW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      state_q <= STATE_RST;
      g_q     <= '0;
      idx_q   <= '0;
      ptr_q   <= IDXW'(PTR_RST);
      guard_q <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      guard_q <= guard_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  assign G         = g_q;
  assign grant_idx = idx_q;
  assign busy      = (state_q == ST_GRANT);
  assign hold_err  = err_q;

endmodule

// File: tb/tb_join_rr_arbiter.sv
// Bench for join_rr_arbiter: directed handshake scenarios plus randomized stress against
// a cycle-level reference model; three configurations share one clock and master reset.
module tb_join_rr_arbiter;

  typedef struct packed {
    int   st;     // 0 idle, 1 grant, 2 guard
    int   w;
    int   ptr;
    int   gleft;
    int   held;
    logic err;
  } mdl_t;

  logic clk, mr;

  logic [7:0] send_a, ack_a, z_a, g_a;
  logic [2:0] idx_a;
  logic       busy_a, err_a;
  logic [3:0] send_b, ack_b, z_b, g_b;
  logic [1:0] idx_b;
  logic       busy_b, err_b;
  logic [1:0] send_c, ack_c, z_c, g_c;
  logic [0:0] idx_c;
  logic       busy_c, err_c;

  join_rr_arbiter #(.N_CH(8), .MODE_RR(1), .GUARD(2), .HOLD_MAX(6)) u_dut_a (
    .CLK(clk), .MR(mr), .Send_in(send_a), .Ack_out(ack_a), .Z(z_a),
    .G(g_a), .grant_idx(idx_a), .busy(busy_a), .hold_err(err_a));

  join_rr_arbiter #(.N_CH(4), .MODE_RR(0), .GUARD(0), .HOLD_MAX(0)) u_dut_b (
    .CLK(clk), .MR(mr), .Send_in(send_b), .Ack_out(ack_b), .Z(z_b),
    .G(g_b), .grant_idx(idx_b), .busy(busy_b), .hold_err(err_b));

  join_rr_arbiter u_dut_c (
    .CLK(clk), .MR(mr), .Send_in(send_c), .Ack_out(ack_c), .Z(z_c),
    .G(g_c), .grant_idx(idx_c), .busy(busy_c), .hold_err(err_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  mdl_t ma, mb;
  logic [7:0] prev_g_a;
  int waitc [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Next state from the behavioural rules: pick, hold until release/timeout, gap, idle.
  function automatic mdl_t mdl_step(input mdl_t m, input logic [7:0] req, input int n,
                                    input bit rr, input int guard, input int hmax);
    mdl_t r;
    bit   found;
    int   c;
    r = m;
    found = 1'b0;
    if (m.st == 0) begin
      for (int k = 0; k < n; k++) begin
        c = ((rr ? m.ptr : 0) + k) % n;
        if (!found && req[c]) begin
          found = 1'b1; r.st = 1; r.w = c; r.held = 0;
        end
      end
    end else if (m.st == 1) begin
      r.held = m.held + 1;
      if (!req[m.w] || (hmax > 0 && r.held >= hmax)) begin
        if (req[m.w]) r.err = 1'b1;
        if (rr) r.ptr = (m.w + 1) % n;
        r.st    = (guard > 0) ? 2 : 0;
        r.gleft = guard;
      end
    end else begin
      r.gleft = m.gleft - 1;
      if (r.gleft == 0) r.st = 0;
    end
    return r;
  endfunction

  task automatic cmp_mdl(input string tag, input mdl_t m, input logic [31:0] g,
                         input logic [31:0] idx, input logic bsy, input logic err);
    logic [31:0] eg;
    eg = (m.st == 1) ? (32'd1 << m.w) : 32'd0;
    chk({tag, ".G"}, g, eg);
    chk({tag, ".busy"}, 32'(bsy), 32'(m.st == 1));
    chk({tag, ".hold_err"}, 32'(err), 32'(m.err));
    if (m.st == 1) chk({tag, ".idx"}, idx, 32'(m.w));
  endtask

  // Called at a falling edge with inputs set; advances one clock and checks A and B.
  task automatic cycle();
    logic [7:0] ra;
    logic [3:0] rb;
    ra = send_a & ack_a & z_a;
    rb = send_b & ack_b & z_b;
    @(posedge clk);
    ma = mdl_step(ma, ra, 8, 1'b1, 2, 6);
    mb = mdl_step(mb, {4'b0, rb}, 4, 1'b0, 0, 0);
    @(negedge clk);
    cmp_mdl("A", ma, 32'(g_a), 32'(idx_a), busy_a, err_a);
    cmp_mdl("B", mb, 32'(g_b), 32'(idx_b), busy_b, err_b);
    chk("A.onehot0", 32'($onehot0(g_a)), 32'd1);
    // A continuously requesting channel may see at most 7 other grants before its own.
    for (int j = 0; j < 8; j++) begin
      if (!ra[j] || g_a[j]) waitc[j] = 0;
      else if (g_a != 8'h00 && prev_g_a == 8'h00) begin
        waitc[j]++;
        chk("A.fair", 32'(waitc[j] <= 7), 32'd1);
      end
    end
    prev_g_a = g_a;
  endtask

  task automatic mr_pulse();
    #2 mr = 1'b1;
    #1;
    chk("A.G_async", 32'(g_a), 32'd0);
    chk("B.G_async", 32'(g_b), 32'd0);
    chk("C.G_async", 32'(g_c), 32'd0);
    chk("C.busy_async", 32'(busy_c), 32'd0);
    chk("A.err_async", 32'(err_a), 32'd0);
    ma = '0;
    mb = '0;
    prev_g_a = '0;
    for (int j = 0; j < 8; j++) waitc[j] = 0;
    #1 mr = 1'b0;
  endtask

  initial begin
    bit sticky;
    mr = 1'b1;
    send_a = '0; ack_a = '0; z_a = '0;
    send_b = '0; ack_b = '0; z_b = '0;
    send_c = '0; ack_c = '0; z_c = '0;
    ma = '0; mb = '0; prev_g_a = '0;
    for (int j = 0; j < 8; j++) waitc[j] = 0;
    repeat (2) @(negedge clk);
    mr = 1'b0;

    chk("rst.G_a", 32'(g_a), 32'd0);
    chk("rst.G_b", 32'(g_b), 32'd0);
    chk("rst.G_c", 32'(g_c), 32'd0);
    chk("rst.idx_a", 32'(idx_a), 32'd0);
    chk("rst.busy_a", 32'(busy_a), 32'd0);
    chk("rst.err_a", 32'(err_a), 32'd0);

    // Two-channel round robin, guard 1.
    send_c = 2'b11; ack_c = 2'b11; z_c = 2'b11;
    cycle();
    chk("C.first_G", 32'(g_c), 32'd1);
    chk("C.first_idx", 32'(idx_c), 32'd0);
    chk("C.first_busy", 32'(busy_c), 32'd1);
    send_c = 2'b10;
    cycle();
    chk("C.rel_G", 32'(g_c), 32'd0);
    send_c = 2'b11;
    cycle();
    chk("C.gap_G", 32'(g_c), 32'd0);
    cycle();
    chk("C.rr_G", 32'(g_c), 32'd2);
    chk("C.rr_idx", 32'(idx_c), 32'd1);
    cycle();
    chk("C.hold_G", 32'(g_c), 32'd2);
    mr_pulse();
    cycle();
    chk("C.post_mr_G", 32'(g_c), 32'd1);
    z_c = 2'b10;
    cycle();
    chk("C.zdrop_G", 32'(g_c), 32'd0);
    cycle();
    chk("C.zdrop_gap", 32'(g_c), 32'd0);
    cycle();
    chk("C.zdrop_next", 32'(g_c), 32'd2);
    send_c = 2'b00;
    cycle();
    chk("C.err", 32'(err_c), 32'd0);

    // Watchdog on A: ch0 never releases.
    ack_a = 8'hFF; z_a = 8'hFF; send_a = 8'h03;
    cycle();
    chk("A.wd_first", 32'(g_a), 32'd1);
    repeat (5) cycle();
    chk("A.wd_held", 32'(g_a), 32'd1);
    chk("A.wd_noerr", 32'(err_a), 32'd0);
    cycle();
    chk("A.wd_rel", 32'(g_a), 32'd0);
    chk("A.wd_err", 32'(err_a), 32'd1);
    cycle();
    cycle();
    chk("A.wd_gap", 32'(g_a), 32'd0);
    cycle();
    chk("A.wd_next", 32'(g_a), 32'd2);
    send_a = 8'h00;
    repeat (4) cycle();
    chk("A.err_sticky", 32'(err_a), 32'd1);

    // Randomized stress on A and B, alternating short and long holds.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) mr_pulse();
      sticky = ((i / 200) % 2) == 1;
      for (int j = 0; j < 8; j++) begin
        if ($urandom_range(sticky ? 15 : 3) == 0) send_a[j] = ~send_a[j];
        ack_a[j] = ($urandom_range(15) != 0);
        z_a[j]   = ($urandom_range(15) != 0);
      end
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(sticky ? 15 : 3) == 0) send_b[j] = ~send_b[j];
        ack_b[j] = ($urandom_range(15) != 0);
        z_b[j]   = ($urandom_range(15) != 0);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
